// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared LSU funct3 encodings, state type and size/legality decode.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Byte count for an access; the 2'b11 size is illegal and never reaches XFER.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   lsu_size = 3'd1;
            2'b01:   lsu_size = 3'd2;
            default: lsu_size = 3'd4;
        endcase
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            lsu_illegal = (funct3 >= 3'b011);
        else
            lsu_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu_ext
// Brief    : Sign/zero extension of an assembled load word according to funct3.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu_ext
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            LSU_B:   o_data = {{24{i_word[7]}}, i_word[7:0]};
            LSU_H:   o_data = {{16{i_word[15]}}, i_word[15:0]};
            LSU_BU:  o_data = {24'd0, i_word[7:0]};
            LSU_HU:  o_data = {16'd0, i_word[15:0]};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Brief    : Byte-serial RISC-V load/store unit over an 8-bit memory port.
//            Optional RISCV_LSU_MISALIGN_TRAP_EN turns misaligned H/W into errors.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       w_data,
    output logic [31:0]       r_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [23:0] r_wdata_hi;
    logic [31:0] r_result;
    logic [1:0]  r_k;
    logic [2:0]  r_n;
    logic        r_err;

    logic        w_accept;
    logic        w_bad;
    logic        w_last;
    logic [7:0]  w_next_byte;
    logic [31:0] w_assembled;
    logic [31:0] w_ext;

    always_comb begin
        w_bad = lsu_illegal(req_we, req_funct3);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && i_addr[0])
            w_bad = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00))
            w_bad = 1'b1;
`endif
    end

    assign w_last = ({1'b0, r_k} == (r_n - 3'd1));

    // Byte k+1 of the store data, presented after the edge that retires byte k.
    always_comb begin
        w_next_byte = r_wdata_hi[23:16];
        case (r_k)
            2'd0:    w_next_byte = r_wdata_hi[7:0];
            2'd1:    w_next_byte = r_wdata_hi[15:8];
            default: w_next_byte = r_wdata_hi[23:16];
        endcase
    end

    // Merge the byte on the bus now so the final byte is visible at the last edge.
    always_comb begin
        w_assembled = r_result;
        case (r_k)
            2'd0:    w_assembled[7:0]   = mem_rdata;
            2'd1:    w_assembled[15:8]  = mem_rdata;
            2'd2:    w_assembled[23:16] = mem_rdata;
            default: w_assembled[31:24] = mem_rdata;
        endcase
    end

    riscv_lsu_ext u_ext (
        .i_word   (w_assembled),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_bad ? RESP : XFER;
                end
            end
            XFER: begin
                if (w_last)
                    w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign resp_err = resp_valid & r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_wdata_hi <= 24'd0;
            r_result   <= 32'd0;
            r_k        <= 2'd0;
            r_n        <= 3'd1;
            r_err      <= 1'b0;
            r_data     <= 32'd0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            mem_we     <= 1'b0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_wdata_hi <= w_data[31:8];
            r_result   <= 32'd0;
            r_k        <= 2'd0;
            r_n        <= lsu_size(req_funct3);
            r_err      <= w_bad;
            if (!w_bad) begin
                mem_addr <= i_addr;
                mem_we   <= req_we;
                if (req_we)
                    mem_wdata <= w_data[7:0];
            end
        end else if (r_state == XFER) begin
            r_k <= r_k + 2'd1;
            if (!r_we)
                r_result <= w_assembled;
            if (w_last) begin
                mem_we <= 1'b0;
                if (!r_we)
                    r_data <= w_ext;
            end else begin
                mem_addr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (r_we)
                    mem_wdata <= w_next_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the core datapath and `riscv_data_mem`. It takes one load or store request per handshake and decodes funct3 into byte, halfword or word size with sign or zero extension. It runs the access byte-serially over an 8-bit memory port, one byte per clock, in RISC-V little-endian order. It then returns the extended load result, or a store completion, with a single-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 32: address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `i_addr`  in  ADDR_W  byte address of the lowest byte.
- `w_data`  in  32  store data; only low 8/16/32 bits are used.
- `r_data`  out  32  extended load result; reset 0.
- `resp_valid`  out  1  one-cycle completion pulse; reset 0.
- `resp_err`  out  1  qualified by `resp_valid`; reset 0.
- `mem_addr`  out  ADDR_W  byte address to `riscv_data_mem`; reset 0.
- `mem_wdata`  out  8  byte to write; reset 0.
- `mem_we`  out  1  byte write enable; reset 0.
- `mem_rdata`  in  8  combinational read byte at `mem_addr`.

## Operation
- States: IDLE, XFER, RESP.
- On accept in IDLE:
  - Latch we, funct3, base address and w_data.
  - Set byte count n = 1/2/4 from funct3[1:0].
  - Clear byte index k to 0.
  - Go to XFER.
- Illegal funct3 is load 011/110/111 or store with funct3 ≥ 011. On accept it goes straight to RESP with err=1 and performs no memory access.
- XFER:
  - Each cycle `mem_addr` = base + k, wrapping modulo 2^ADDR_W.
  - Store: `mem_we`=1 and `mem_wdata` = w_data[8k+7:8k].
  - Load: `mem_we`=0; `mem_rdata` is captured into result byte k at the rising edge.
  - k increments each cycle; after byte n-1 go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - On a load, `r_data` takes the assembled value. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - On a store or an error, `r_data` holds its previous value.
- `mem_we` is 0 in every state other than XFER-store.
- `mem_addr` and `mem_wdata` hold their last values outside XFER.
- `req_*` inputs are ignored outside IDLE; the core must hold them stable until `resp_valid`.

## Timing
- Accept at edge E0. Bytes occupy cycles 1..n. `resp_valid` is high in cycle n+1.
- Latency: LB 2, LH 3, LW 4+1=5 cycles to response. Error response arrives in cycle 1.
- `req_ready` returns high in the cycle after RESP. Back-to-back throughput is n+2 cycles per request.
- Reset asserted at any edge:
  - Next cycle is IDLE with all outputs at reset values.
  - A partially written store is not rolled back; bytes already written stay.
  - No `resp_valid` is produced for the aborted request.
- Address wrap: a word access at 0xFFFF_FFFE touches bytes 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.

## Configuration
- `RISCV_LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with addr[0]≠0, or a word with addr[1:0]≠0, is treated like illegal funct3.
  - Response in cycle 1 with `resp_err`=1 and no memory access.
- Not defined: misaligned accesses proceed byte-serially as normal and complete with err=0.

## Structure
- `riscv_pkg` holds:
  - The funct3 constants (LSU_B=3'b000, LSU_H=3'b001, LSU_W=3'b010, LSU_BU=3'b100, LSU_HU=3'b101).
  - The `lsu_state_t` enum {IDLE, XFER, RESP}.
  - The size-decode function returning n.
- Sub-module `riscv_lsu_ext`: combinational extender taking the assembled 32-bit value and funct3 and producing `r_data`.

## Test plan
- LW: memory bytes 0x100..0x103 = 11 22 33 44, LW addr 0x100 -> `resp_valid` in cycle 5, `r_data`=0x44332211, `resp_err`=0.
- LB/LBU: byte 0x80 at 0x200.
  - LB -> `r_data`=0xFFFFFF80 in cycle 2.
  - LBU -> `r_data`=0x00000080.
- SH: w_data=0xDEADBEEF, addr 0x300 -> `mem_we` high cycles 1-2 with 0xEF@0x300, 0xBE@0x301; byte 0x302 unchanged; `r_data` unchanged.
- Misaligned LW at 0x101:
  - With macro: `resp_err`=1 in cycle 1 and `mem_we` never asserted.
  - Without macro: `r_data` = bytes 0x104..0x101 little-endian, err=0.
- Illegal funct3=3'b011 load -> cycle 1 response, err=1, `mem_addr` unchanged.
- SW at 0x400 of 0xAABBCCDD, `rst` asserted after 2 bytes written -> IDLE next cycle, no `resp_valid`, 0x400=DD, 0x401=CC, 0x402/0x403 untouched.
